sram_arbiter: RTL and testbench

- Shares one single-port 32-bit SRAM between the IF instruction-fetch port and the MEM load/store port.
- Sequences each access through a fixed number of wait states.
- Returns a one-cycle ready pulse to the requester it served; the pipeline stall logic holds the requesting stage until that pulse.
- Sits between the CPU core's instruction and data bus ports and the board SRAM.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_wait_cnt.sv | 29 ++
 rtl/sram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, grant owner and the
// full-word byte-enable constant.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } grant_t;

  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter that times the SRAM wait states; zero marks the
// last access cycle.
module sram_wait_cnt #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = $clog2(WAIT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between the IF and MEM ports with fixed wait
// states. Define SRAM_ARB_RR_EN for round-robin instead of MEM-first priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_ready_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  input  logic [3:0]        mem_sel_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_ready_o,
  output logic              sram_ce_o,
  output logic              sram_oe_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  state_t            state_reg, state_next;
  grant_t            grant_reg, gnt_sel;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        sel_reg;
  logic              we_reg;
  logic [31:0]       if_data_reg, mem_data_reg;
  logic              cnt_zero;
  logic              grant_now;
  logic              unused_addr_bits;

  // Word addressing: byte lanes and bits beyond the SRAM are dropped.
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

`ifdef SRAM_ARB_RR_EN
  grant_t last_grant_reg;

  always_comb begin
    gnt_sel = GNT_NONE;
    if (mem_ce_i && if_ce_i)
      gnt_sel = (last_grant_reg == GNT_MEM) ? GNT_IF : GNT_MEM;
    else if (mem_ce_i)
      gnt_sel = GNT_MEM;
    else if (if_ce_i)
      gnt_sel = GNT_IF;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant_reg <= GNT_IF;
    else if (grant_now)
      last_grant_reg <= gnt_sel;
  end
`else
  always_comb begin
    gnt_sel = GNT_NONE;
    if (mem_ce_i)
      gnt_sel = GNT_MEM;
    else if (if_ce_i)
      gnt_sel = GNT_IF;
  end
`endif

  assign grant_now = (state_reg == IDLE) && (gnt_sel != GNT_NONE);

  sram_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_now),
    .load_val(CNT_W'(WAIT_CYCLES - 1)),
    .dec     (state_reg == ACCESS),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt_sel != GNT_NONE) state_next = ACCESS;
      ACCESS:  if (cnt_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request is captured once at grant; the requester may drop ce afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg    <= GNT_NONE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      sel_reg      <= '0;
      we_reg       <= 1'b0;
      if_data_reg  <= '0;
      mem_data_reg <= '0;
    end else begin
      if (grant_now) begin
        grant_reg <= gnt_sel;
        if (gnt_sel == GNT_MEM) begin
          addr_reg  <= mem_addr_i[ADDR_W+1:2];
          wdata_reg <= mem_data_i;
          sel_reg   <= mem_sel_i;
          we_reg    <= mem_we_i;
        end else begin
          addr_reg  <= if_addr_i[ADDR_W+1:2];
          wdata_reg <= '0;
          sel_reg   <= SEL_ALL;
          we_reg    <= 1'b0;
        end
      end
      if ((state_reg == ACCESS) && cnt_zero && !we_reg) begin
        if (grant_reg == GNT_IF)
          if_data_reg <= sram_data_i;
        else if (grant_reg == GNT_MEM)
          mem_data_reg <= sram_data_i;
      end
      if (state_reg == DONE)
        grant_reg <= GNT_NONE;
    end
  end

  always_comb begin
    sram_ce_o   = 1'b0;
    sram_oe_o   = 1'b0;
    sram_we_o   = 1'b0;
    sram_be_o   = '0;
    sram_addr_o = '0;
    sram_data_o = '0;
    if_ready_o  = 1'b0;
    mem_ready_o = 1'b0;
    case (state_reg)
      ACCESS: begin
        sram_ce_o   = 1'b1;
        sram_we_o   = we_reg;
        sram_oe_o   = !we_reg;
        sram_be_o   = sel_reg;
        sram_addr_o = addr_reg;
        sram_data_o = wdata_reg;
      end
      DONE: begin
        if_ready_o  = (grant_reg == GNT_IF);
        mem_ready_o = (grant_reg == GNT_MEM);
      end
      default: ;
    endcase
  end

  assign if_data_o  = if_data_reg;
  assign mem_data_o = mem_data_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural byte-enabled SRAM.
// Inputs change 1 time unit after posedge; outputs are checked there too.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic        sram_ce_o, sram_oe_o, sram_we_o;
  logic [3:0]  sram_be_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_data_o;
  logic [31:0] sram_data_i;

  logic [31:0] mem [256];
  int          total = 0;
  int          passed = 0;
  logic [3:0]  exp_mem;
  logic [3:0]  exp_if;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(2), .ADDR_W(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_ce_i    (if_ce_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_ready_o (if_ready_o),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .mem_sel_i  (mem_sel_i),
    .mem_data_o (mem_data_o),
    .mem_ready_o(mem_ready_o),
    .sram_ce_o  (sram_ce_o),
    .sram_oe_o  (sram_oe_o),
    .sram_we_o  (sram_we_o),
    .sram_be_o  (sram_be_o),
    .sram_addr_o(sram_addr_o),
    .sram_data_o(sram_data_o),
    .sram_data_i(sram_data_i)
  );

  assign sram_data_i = mem[sram_addr_o[7:0]];

  always @(posedge clk) begin
    if (sram_ce_o && sram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (sram_be_o[b]) mem[sram_addr_o[7:0]][b*8 +: 8] <= sram_data_o[b*8 +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'h2401_0005;
    repeat (2) tick();
    rst = 1'b0;

    chk("rst_ce", sram_ce_o, 0);
    chk("rst_oe", sram_oe_o, 0);
    chk("rst_we", sram_we_o, 0);
    chk("rst_be", sram_be_o, 0);
    chk("rst_addr", sram_addr_o, 0);
    chk("rst_wdata", sram_data_o, 0);
    chk("rst_if_ready", if_ready_o, 0);
    chk("rst_mem_ready", mem_ready_o, 0);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_mem_data", mem_data_o, 0);

    // IF read of word 4
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
    tick();
    chk("t1_c1_ce", sram_ce_o, 1);
    chk("t1_c1_oe", sram_oe_o, 1);
    chk("t1_c1_we", sram_we_o, 0);
    chk("t1_c1_addr", sram_addr_o, 4);
    chk("t1_c1_be", sram_be_o, 4'hF);
    chk("t1_c1_ready", if_ready_o, 0);
    tick();
    chk("t1_c2_oe", sram_oe_o, 1);
    chk("t1_c2_addr", sram_addr_o, 4);
    tick();
    chk("t1_c3_if_ready", if_ready_o, 1);
    chk("t1_c3_if_data", if_data_o, 32'h2401_0005);
    chk("t1_c3_mem_ready", mem_ready_o, 0);
    chk("t1_c3_ce", sram_ce_o, 0);
    $display("txn IF read addr=%h data=%h", if_addr_i, if_data_o);
    if_ce_i = 1'b0;
    tick();
    chk("t1_c4_if_ready", if_ready_o, 0);

    // MEM write of the low half of word 65
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0104;
    mem_data_i = 32'hDEAD_BEEF; mem_sel_i = 4'b0011;
    tick();
    chk("t2_c1_we", sram_we_o, 1);
    chk("t2_c1_oe", sram_oe_o, 0);
    chk("t2_c1_be", sram_be_o, 4'b0011);
    chk("t2_c1_addr", sram_addr_o, 65);
    chk("t2_c1_wdata", sram_data_o, 32'hDEAD_BEEF);
    tick();
    chk("t2_c2_we", sram_we_o, 1);
    chk("t2_c2_addr", sram_addr_o, 65);
    tick();
    chk("t2_c3_mem_ready", mem_ready_o, 1);
    chk("t2_c3_oe", sram_oe_o, 0);
    chk("t2_c3_mem_data_kept", mem_data_o, 0);
    $display("txn MEM write addr=%h data=%h sel=%b", mem_addr_i, mem_data_i, mem_sel_i);
    mem_ce_i = 1'b0;
    tick();

    // Read back word 65
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_data_i = '0;
    repeat (3) tick();
    chk("t2_rd_ready", mem_ready_o, 1);
    chk("t2_rd_data", mem_data_o, 32'h0000_BEEF);
    $display("txn MEM read addr=%h data=%h", mem_addr_i, mem_data_o);
    mem_ce_i = 1'b0;
    tick();

    // Simultaneous requests: MEM first, IF next
    reset_pulse();
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0104; mem_sel_i = 4'hF;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("t3_no_overlap", {31'b0, if_ready_o & mem_ready_o}, 0);
      if (c == 2) chk("t3_c2_addr", sram_addr_o, 65);
      if (c == 3) begin
        chk("t3_c3_mem_ready", mem_ready_o, 1);
        chk("t3_c3_mem_data", mem_data_o, 32'h0000_BEEF);
        $display("txn MEM read addr=%h data=%h", mem_addr_i, mem_data_o);
        mem_ce_i = 1'b0;
      end
      if (c == 6) chk("t3_c6_addr", sram_addr_o, 4);
      if (c == 7) begin
        chk("t3_c7_if_ready", if_ready_o, 1);
        chk("t3_c7_if_data", if_data_o, 32'h2401_0005);
        $display("txn IF read addr=%h data=%h", if_addr_i, if_data_o);
        if_ce_i = 1'b0;
      end
    end
    tick();

    // Both ports held for four transfers
`ifdef SRAM_ARB_RR_EN
    exp_mem = 4'b0101;
`else
    exp_mem = 4'b1111;
`endif
    exp_if = ~exp_mem;
    reset_pulse();
    if_ce_i = 1'b1; mem_ce_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (3) tick();
      chk($sformatf("t4_x%0d_mem_ready", k), mem_ready_o, exp_mem[k]);
      chk($sformatf("t4_x%0d_if_ready", k), if_ready_o, exp_if[k]);
      $display("txn held-requests transfer %0d mem_ready=%0b if_ready=%0b", k, mem_ready_o, if_ready_o);
      if (k == 3) begin
        if_ce_i = 1'b0; mem_ce_i = 1'b0;
      end
      tick();
    end

    // Reset during ACCESS abandons the IF read
    reset_pulse();
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
    tick();
    chk("t5_c1_ce", sram_ce_o, 1);
    rst = 1'b1; if_ce_i = 1'b0;
    tick();
    chk("t5_rst_ce", sram_ce_o, 0);
    chk("t5_rst_oe", sram_oe_o, 0);
    chk("t5_rst_addr", sram_addr_o, 0);
    chk("t5_rst_if_ready", if_ready_o, 0);
    chk("t5_rst_if_data", if_data_o, 0);
    rst = 1'b0;
    tick();
    chk("t5_after1_if_ready", if_ready_o, 0);
    tick();
    chk("t5_after2_if_ready", if_ready_o, 0);
    chk("t5_after2_ce", sram_ce_o, 0);
    if_ce_i = 1'b1;
    repeat (3) tick();
    chk("t5_new_if_ready", if_ready_o, 1);
    chk("t5_new_if_data", if_data_o, 32'h2401_0005);
    $display("txn IF read after reset addr=%h data=%h", if_addr_i, if_data_o);
    if_ce_i = 1'b0;
    tick();

    // MEM request dropped after the first ACCESS cycle
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0010; mem_sel_i = 4'hF;
    tick();
    mem_ce_i = 1'b0;
    tick();
    chk("t6_c2_ce", sram_ce_o, 1);
    tick();
    chk("t6_c3_mem_ready", mem_ready_o, 1);
    chk("t6_c3_mem_data", mem_data_o, 32'h2401_0005);
    $display("txn MEM read (dropped ce) addr=%h data=%h", mem_addr_i, mem_data_o);
    tick();
    chk("t6_c4_ce", sram_ce_o, 0);
    chk("t6_c4_mem_ready", mem_ready_o, 0);
    tick();
    chk("t6_c5_ce", sram_ce_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
